// File: rtl/dw_addsub_pipe_if.sv
// Stream bundle for dw_addsub_pipe: operand side (in_*) and result side (out_*).
// The unit itself connects through the slave modport; the producer/consumer side uses master.
interface dw_addsub_pipe_if #(
  parameter int width = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] A;
  logic [width-1:0] B;
  logic             CI;
  logic             MODE;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] DIFF;
  logic             CO;
  logic             OVF;

  modport slave (
    input  in_valid, A, B, CI, MODE, out_ready,
    output in_ready, out_valid, DIFF, CO, OVF
  );

  modport master (
    output in_valid, A, B, CI, MODE, out_ready,
    input  in_ready, out_valid, DIFF, CO, OVF
  );
endinterface

// File: rtl/dw_addsub_pipe.sv
// Pipelined add/subtract: the operand is cut into `stages` carry-chained segments,
// one segment per stage, with skewed operands and deskewed results travelling alongside.
module dw_addsub_pipe #(
  parameter int width  = 32,
  parameter int stages = 4
) (
  input logic            clk,
  input logic            rst,
  dw_addsub_pipe_if.slave bus
);
  localparam int S = width / stages;
  localparam int L = stages - 1;
  localparam logic [width-1:0] segones = width'({S{1'b1}});

  logic [stages-1:0][width-1:0] a, b, r;
  logic [stages-1:0]            c, md, v;

  logic [stages-1:0][width-1:0] ain, bin, rin, nr;
  logic [stages-1:0]            cin, mdin, vin, nc;
  logic [stages-1:0][S:0]       sum;

  logic adv;
  logic unused;

  assign adv = !(v[L] && !bus.out_ready);

  for (genvar k = 0; k < stages; k++) begin : g_stage
    localparam logic [width-1:0] segmask = segones << (k * S);

    // Subtract is folded into an add at the input: A + ~B with carry-in ~CI.
    if (k == 0) begin : g_first
      assign ain[k]  = bus.A;
      assign bin[k]  = bus.MODE ? bus.B : ~bus.B;
      assign rin[k]  = '0;
      assign cin[k]  = bus.MODE ? bus.CI : ~bus.CI;
      assign mdin[k] = bus.MODE;
      assign vin[k]  = bus.in_valid;
    end else begin : g_next
      assign ain[k]  = a[k-1];
      assign bin[k]  = b[k-1];
      assign rin[k]  = r[k-1];
      assign cin[k]  = c[k-1];
      assign mdin[k] = md[k-1];
      assign vin[k]  = v[k-1];
    end

    assign sum[k] = {1'b0, ain[k][k*S +: S]} + {1'b0, bin[k][k*S +: S]} + (S+1)'(cin[k]);
    assign nr[k]  = (rin[k] & ~segmask) | (width'(sum[k][S-1:0]) << (k * S));

    // The last stage stores the user-visible carry, so a subtract's borrow is the inverted carry.
    if (k == L) begin : g_co
      assign nc[k] = mdin[k] ? sum[k][S] : ~sum[k][S];
    end else begin : g_carry
      assign nc[k] = sum[k][S];
    end
  end

  // One shared enable: the whole pipe freezes while a result waits at the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v  <= '0;
      c  <= '0;
      md <= '0;
      a  <= '0;
      b  <= '0;
      r  <= '0;
    end else if (adv) begin
      v  <= vin;
      c  <= nc;
      md <= mdin;
      a  <= ain;
      b  <= bin;
      r  <= nr;
    end
  end

  // b holds the effective addend, so one overflow rule covers both modes.
  assign bus.in_ready  = adv;
  assign bus.out_valid = v[L];
  assign bus.DIFF      = r[L];
  assign bus.CO        = c[L];
  assign bus.OVF       = (a[L][width-1] == b[L][width-1]) && (r[L][width-1] != a[L][width-1]);

  assign unused = ^{a[L], b[L], md[L]};
endmodule

// File: tb/tb_dw_addsub_pipe.sv
// Self-checking bench for dw_addsub_pipe: directed corner cases, random mixed-mode streams,
// backpressure and mid-stream reset, all scored against an arithmetic reference model.
module tb_dw_addsub_pipe;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dw_addsub_pipe_if #(.width(W)) bif();

  dw_addsub_pipe #(.width(W), .stages(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    logic [W+1:0] res;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           checks    = 0;
  int           errors    = 0;
  int           cyc       = 0;
  int           stallLeft = 0;
  logic         randReady = 1'b0;
  logic         checkLat  = 1'b1;
  logic         prevStall = 1'b0;
  logic [W+1:0] prevOut   = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic for {CO,DIFF}, true signed range test for OVF.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic mode);
    logic [W:0] full;
    longint     sa, sb, sr;
    logic       ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mode) begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      sr   = sa + sb + longint'(ci);
    end else begin
      full = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
      sr   = sa - sb - longint'(ci);
    end
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    if (stallLeft > 0) begin
      bif.out_ready = 1'b0;
      stallLeft--;
    end else begin
      bif.out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: handshake rule, hold-while-stalled, and in-order scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      checkOutput("inReady", 64'(bif.in_ready), 64'(!(bif.out_valid && !bif.out_ready)));
      if (prevStall) begin
        checkOutput("holdValid", 64'(bif.out_valid), 64'd1);
        checkOutput("holdData", 64'({bif.OVF, bif.CO, bif.DIFF}), 64'(prevOut));
      end
      if (bif.out_valid && bif.out_ready) begin
        if (q.size() == 0) begin
          checkOutput("spurious", 64'(bif.out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          checkOutput("result", 64'({bif.OVF, bif.CO, bif.DIFF}), 64'(e.res));
          if (checkLat) checkOutput("latency", 64'(cyc - e.cyc), 64'(N));
        end
      end
      prevStall = bif.out_valid && !bif.out_ready;
      prevOut   = {bif.OVF, bif.CO, bif.DIFF};
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, input logic mode, input logic [W+1:0] exp);
    logic acc;
    int   n;
    bif.A        = a;
    bif.B        = b;
    bif.CI       = ci;
    bif.MODE     = mode;
    bif.in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bif.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) q.push_back('{exp, cyc});
    else checkOutput("acceptTimeout", 64'(acc), 64'd1);
  endtask

  task automatic randomOp();
    logic [W-1:0] a, b;
    logic         ci, md;
    a  = $urandom;
    b  = $urandom;
    ci = 1'($urandom_range(0, 1));
    md = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) b = a;
    applyStimulus(a, b, ci, md, model(a, b, ci, md));
  endtask

  task automatic idle(input int n);
    bif.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    bif.in_valid = 1'b0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bif.in_valid = 1'b0;
    bif.A        = '0;
    bif.B        = '0;
    bif.CI       = 1'b0;
    bif.MODE     = 1'b0;
    #2;
    checkOutput("rstValid", 64'(bif.out_valid), 64'd0);
    checkOutput("rstDiff", 64'(bif.DIFF), 64'd0);
    checkOutput("rstCo", 64'(bif.CO), 64'd0);
    checkOutput("rstOvf", 64'(bif.OVF), 64'd0);
    checkOutput("rstInReady", 64'(bif.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corners, expected values written as {OVF, CO, DIFF}.
    applyStimulus(32'h0000_0050, 32'h0000_0020, 1'b0, 1'b0, {2'b00, 32'h0000_0030});
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, {2'b01, 32'hFFFF_FFFE});
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, {2'b10, 32'h7FFF_FFFF});
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, {2'b00, 32'h0001_0000});
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, {2'b01, 32'h0000_0000});
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, {2'b10, 32'h8000_0000});
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, {2'b01, 32'hFFFF_FFFF});
    drain();

    for (int i = 0; i < 100; i++) randomOp();
    drain();

    checkLat = 1'b0;
    for (int i = 0; i < 6; i++) randomOp();
    stallLeft = 5;
    for (int i = 0; i < 10; i++) randomOp();
    drain();

    randReady = 1'b1;
    for (int i = 0; i < 60; i++) randomOp();
    drain();
    randReady = 1'b0;
    idle(2);
    checkLat = 1'b1;

    for (int i = 0; i < 6; i++) randomOp();
    bif.in_valid = 1'b0;
    #1;
    checkOutput("preRstValid", 64'(bif.out_valid), 64'd1);
    #1 rst = 1'b1;
    q.delete();
    #1;
    checkOutput("midRstValid", 64'(bif.out_valid), 64'd0);
    checkOutput("midRstDiff", 64'(bif.DIFF), 64'd0);
    checkOutput("midRstCo", 64'(bif.CO), 64'd0);
    checkOutput("midRstOvf", 64'(bif.OVF), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("postRstInReady", 64'(bif.in_ready), 64'd1);
    idle(8);
    randomOp();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
